// File: rtl/wx_sched.sv
// Sequencer for the 3-PE W·x array: holds W, takes samples over valid/ready, captures s PE_LAT edges after the
// operand load and holds the result until the consumer accepts it; weights are writable only while idle.
module wx_sched #(
  parameter int PE_LAT = 2,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic        [CNT_W-1:0] batch_len,
  output logic                    busy,
  output logic                    done,
  input  logic                    w_we,
  input  logic        [3:0]       w_addr,
  input  logic signed [15:0]      w_data,
  output logic                    w_err,
  input  logic                    x_valid,
  output logic                    x_ready,
  input  logic signed [15:0]      x1,
  input  logic signed [15:0]      x2,
  input  logic signed [15:0]      x3,
  output logic signed [15:0]      d1,
  output logic signed [15:0]      d2,
  output logic signed [15:0]      d3,
  output logic signed [15:0]      e1,
  output logic signed [15:0]      e2,
  output logic signed [15:0]      e3,
  output logic signed [15:0]      f1,
  output logic signed [15:0]      f2,
  output logic signed [15:0]      f3,
  output logic signed [15:0]      p1,
  output logic signed [15:0]      p2,
  output logic signed [15:0]      p3,
  input  logic signed [31:0]      s1,
  input  logic signed [31:0]      s2,
  input  logic signed [31:0]      s3,
  output logic                    y_valid,
  input  logic                    y_ready,
  output logic signed [31:0]      y1,
  output logic signed [31:0]      y2,
  output logic signed [31:0]      y3,
  output logic        [CNT_W-1:0] sample_cnt
);

  typedef enum logic [2:0] {IDLE, RUN, WAIT, OUT, FIN} state_t;

  localparam int WC_W = $clog2(PE_LAT + 1);

  state_t             state;
  state_t             state_nx;
  logic signed [15:0] w_q [9];
  logic [CNT_W-1:0]   len_q;
  logic [CNT_W-1:0]   cnt_inc;
  logic [WC_W-1:0]    wcnt;
  logic               w_ok;

  assign cnt_inc = sample_cnt + CNT_W'(1);
  assign w_ok    = w_we && (state == IDLE) && (w_addr <= 4'd8);

  // Weight registers drive the array directly, so an accepted write shows on d/e/f at the same edge.
  assign d1 = w_q[0];
  assign d2 = w_q[1];
  assign d3 = w_q[2];
  assign e1 = w_q[3];
  assign e2 = w_q[4];
  assign e3 = w_q[5];
  assign f1 = w_q[6];
  assign f2 = w_q[7];
  assign f3 = w_q[8];

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = (state != IDLE);
    x_ready  = (state == RUN);
    y_valid  = (state == OUT);
    done     = (state == FIN);
    case (state)
      IDLE: if (start) state_nx = (batch_len == '0) ? FIN : RUN;
      RUN:  if (x_valid) state_nx = WAIT;
      WAIT: if (wcnt == WC_W'(1)) state_nx = OUT;
      OUT:  if (y_ready) state_nx = (cnt_inc == len_q) ? FIN : RUN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 9; i++) w_q[i] <= '0;
      p1         <= '0;
      p2         <= '0;
      p3         <= '0;
      y1         <= '0;
      y2         <= '0;
      y3         <= '0;
      len_q      <= '0;
      sample_cnt <= '0;
      wcnt       <= '0;
      w_err      <= 1'b0;
    end else begin
      w_err <= w_we && !w_ok;
      if (w_ok) w_q[w_addr] <= w_data;
      if (state == IDLE && start) begin
        len_q      <= batch_len;
        sample_cnt <= '0;
      end
      if (state == RUN && x_valid) begin
        p1   <= x1;
        p2   <= x2;
        p3   <= x3;
        wcnt <= WC_W'(PE_LAT);
      end
      // The counter reaching 1 marks the PE_LAT-th edge after the operand load.
      if (state == WAIT) begin
        wcnt <= wcnt - WC_W'(1);
        if (wcnt == WC_W'(1)) begin
          y1 <= s1;
          y2 <= s2;
          y3 <= s3;
        end
      end
      if (state == OUT && y_ready) sample_cnt <= cnt_inc;
    end
  end

endmodule

// File: tb/tb_wx_sched.sv
// Bench for wx_sched: drives a registered 3-PE array model, checks every cycle against a transaction-level
// reference, and pins the reference with hand-computed results for the directed scenarios.
module tb_wx_sched;

  localparam int PE_LAT = 2;
  localparam int CNT_W  = 16;

  logic                    clk = 1'b0;
  logic                    reset = 1'b1;
  logic                    start = 1'b0;
  logic        [CNT_W-1:0] batch_len = '0;
  logic                    busy, done, w_err, x_ready, y_valid;
  logic                    w_we = 1'b0;
  logic        [3:0]       w_addr = '0;
  logic signed [15:0]      w_data = '0;
  logic                    x_valid = 1'b0;
  logic                    y_ready = 1'b1;
  logic signed [15:0]      x1 = '0, x2 = '0, x3 = '0;
  logic signed [15:0]      d1, d2, d3, e1, e2, e3, f1, f2, f3, p1, p2, p3;
  logic signed [31:0]      s1 = '0, s2 = '0, s3 = '0;
  logic signed [31:0]      y1, y2, y3;
  logic        [CNT_W-1:0] sample_cnt;

  wx_sched #(.PE_LAT(PE_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .start(start), .batch_len(batch_len), .busy(busy), .done(done),
    .w_we(w_we), .w_addr(w_addr), .w_data(w_data), .w_err(w_err),
    .x_valid(x_valid), .x_ready(x_ready), .x1(x1), .x2(x2), .x3(x3),
    .d1(d1), .d2(d2), .d3(d3), .e1(e1), .e2(e2), .e3(e3), .f1(f1), .f2(f2), .f3(f3),
    .p1(p1), .p2(p2), .p3(p3), .s1(s1), .s2(s2), .s3(s3),
    .y_valid(y_valid), .y_ready(y_ready), .y1(y1), .y2(y2), .y3(y3), .sample_cnt(sample_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic note_timeout(input string nm);
    checks++;
    errors++;
    $display("FAIL timeout %s: event not seen, expected within 20 cycles (t=%0t)", nm, $time);
  endtask

  // Array model with PE_LAT=2: one register stage, so s settles one cycle after the operands change.
  int sc1, sc2, sc3;
  always_comb begin
    sc1 = int'(d1) * int'(p1) + int'(d2) * int'(p2) + int'(d3) * int'(p3);
    sc2 = int'(e1) * int'(p1) + int'(e2) * int'(p2) + int'(e3) * int'(p3);
    sc3 = int'(f1) * int'(p1) + int'(f2) * int'(p2) + int'(f3) * int'(p3);
  end
  always @(posedge clk) begin
    s1 <= sc1;
    s2 <= sc2;
    s3 <= sc3;
  end

  // Reference: weights, batch progress and expected results computed as W·x at sample acceptance.
  int  m_w [9];
  int  m_p [3];
  int  m_y [3];
  bit  m_busy = 0, m_take = 0, m_have_y = 0, m_fin = 0, m_werr = 0, mdl_on = 0, was_busy;
  int  m_lat = 0, m_cnt = 0, m_len = 0;
  int  got1[$], got2[$], got3[$];
  int  n_done = 0, n_werr = 0, n_busy = 0, n_xrdy = 0;

  always @(negedge clk) begin
    if (y_valid && y_ready) begin
      got1.push_back(int'(y1));
      got2.push_back(int'(y2));
      got3.push_back(int'(y3));
    end
    if (done) n_done++;
    if (w_err) n_werr++;
    if (busy) n_busy++;
    if (x_ready) n_xrdy++;
    if (mdl_on) begin
      chk("busy", busy, m_busy);
      chk("x_ready", x_ready, m_take);
      chk("y_valid", y_valid, m_have_y);
      chk("done", done, m_fin);
      chk("w_err", w_err, m_werr);
      chk("sample_cnt", sample_cnt, m_cnt);
      chk("d1", d1, m_w[0]); chk("d2", d2, m_w[1]); chk("d3", d3, m_w[2]);
      chk("e1", e1, m_w[3]); chk("e2", e2, m_w[4]); chk("e3", e3, m_w[5]);
      chk("f1", f1, m_w[6]); chk("f2", f2, m_w[7]); chk("f3", f3, m_w[8]);
      chk("p1", p1, m_p[0]); chk("p2", p2, m_p[1]); chk("p3", p3, m_p[2]);
      if (m_have_y) begin
        chk("y1", y1, m_y[0]); chk("y2", y2, m_y[1]); chk("y3", y3, m_y[2]);
      end
    end
    if (reset) begin
      foreach (m_w[i]) m_w[i] = 0;
      foreach (m_p[i]) m_p[i] = 0;
      foreach (m_y[i]) m_y[i] = 0;
      m_busy = 0; m_take = 0; m_have_y = 0; m_fin = 0; m_werr = 0;
      m_lat = 0; m_cnt = 0; m_len = 0;
      mdl_on = 1;
    end else begin
      was_busy = m_busy;
      m_werr = w_we && (was_busy || w_addr > 4'd8);
      if (w_we && !was_busy && w_addr <= 4'd8) m_w[w_addr] = int'(w_data);
      if (!was_busy) begin
        if (start) begin
          m_len = int'(batch_len);
          m_cnt = 0;
          m_busy = 1;
          if (m_len == 0) m_fin = 1;
          else m_take = 1;
        end
      end else if (m_fin) begin
        m_fin = 0;
        m_busy = 0;
      end else if (m_take) begin
        if (x_valid) begin
          m_p[0] = int'(x1); m_p[1] = int'(x2); m_p[2] = int'(x3);
          m_y[0] = m_w[0] * m_p[0] + m_w[1] * m_p[1] + m_w[2] * m_p[2];
          m_y[1] = m_w[3] * m_p[0] + m_w[4] * m_p[1] + m_w[5] * m_p[2];
          m_y[2] = m_w[6] * m_p[0] + m_w[7] * m_p[1] + m_w[8] * m_p[2];
          m_take = 0;
          m_lat = PE_LAT;
        end
      end else if (m_lat > 0) begin
        m_lat--;
        if (m_lat == 0) m_have_y = 1;
      end else if (m_have_y && y_ready) begin
        m_have_y = 0;
        m_cnt++;
        if (m_cnt == m_len) m_fin = 1;
        else m_take = 1;
      end
    end
  end

  int sx [16][3];
  int sst [16];
  int last_lat = 0;

  task automatic cyc_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic set_s(input int k, input int a, input int b, input int c, input int st);
    sx[k][0] = a; sx[k][1] = b; sx[k][2] = c; sst[k] = st;
  endtask

  task automatic do_write(input int a, input int d);
    w_we = 1'b1;
    w_addr = 4'(a);
    w_data = 16'(d);
    cyc_edge();
    w_we = 1'b0;
  endtask

  task automatic send_sample(input int k, input bit rnd);
    int n;
    if (rnd) repeat ($urandom_range(0, 3)) cyc_edge();
    x_valid = 1'b1;
    x1 = 16'(sx[k][0]); x2 = 16'(sx[k][1]); x3 = 16'(sx[k][2]);
    y_ready = (sst[k] == 0);
    n = 0;
    @(negedge clk);
    while (!x_ready && n < 20) begin @(negedge clk); n++; end
    if (!x_ready) note_timeout("x_ready");
    cyc_edge();
    x_valid = 1'b0;
  endtask

  task automatic take_result(input int k);
    int n;
    n = 0;
    do begin @(negedge clk); n++; end while (!y_valid && n < 20);
    last_lat = n;
    if (!y_valid) begin
      note_timeout("y_valid");
      return;
    end
    if (sst[k] > 0) begin
      repeat (sst[k]) cyc_edge();
      y_ready = 1'b1;
      @(negedge clk);
    end
    cyc_edge();
  endtask

  task automatic run_batch(input int len, input int sa, input int sd, input bit rnd);
    int n;
    start = 1'b1;
    batch_len = CNT_W'(len);
    if (sa >= 0) begin w_we = 1'b1; w_addr = 4'(sa); w_data = 16'(sd); end
    cyc_edge();
    start = 1'b0;
    if (sa >= 0) w_we = 1'b0;
    for (int k = 0; k < len; k++) begin
      send_sample(k, rnd);
      take_result(k);
    end
    n = 0;
    @(negedge clk);
    while (!done && n < 20) begin @(negedge clk); n++; end
    if (!done) note_timeout("done");
    cyc_edge();
    chk("sample_cnt_end", sample_cnt, len);
  endtask

  task automatic chk_res(input string nm, input int idx, input int a, input int b, input int c);
    chk({nm, "_y1"}, got1[idx], a);
    chk({nm, "_y2"}, got2[idx], b);
    chk({nm, "_y3"}, got3[idx], c);
  endtask

  initial begin
    int b, nd, nw, nb, nx, len, sa;
    repeat (3) cyc_edge();
    reset = 1'b0;
    chk("rst_busy", busy, 0);
    chk("rst_yv", y_valid, 0);
    chk("rst_xr", x_ready, 0);
    chk("rst_d1", d1, 0);
    chk("rst_cnt", sample_cnt, 0);

    // W rows (1,2,3), (-1,0,1), (4,5,6); one sample of ones
    do_write(0, 1); do_write(1, 2); do_write(2, 3);
    do_write(3, -1); do_write(4, 0); do_write(5, 1);
    do_write(6, 4); do_write(7, 5); do_write(8, 6);
    set_s(0, 1, 1, 1, 0);
    b = got1.size(); nd = n_done;
    run_batch(1, -1, 0, 0);
    chk("s1_count", got1.size() - b, 1);
    chk_res("s1", b, 6, 0, 15);
    chk("s1_latency", last_lat, 3);
    chk("s1_done", n_done - nd, 1);

    // three samples, second result stalled 5 cycles
    set_s(0, 2, -3, 1, 0);
    set_s(1, 0, 0, 0, 5);
    set_s(2, -32768, 0, 0, 0);
    b = got1.size(); nd = n_done;
    run_batch(3, -1, 0, 0);
    chk("s2_count", got1.size() - b, 3);
    chk_res("s2a", b, -1, -1, -1);
    chk_res("s2b", b + 1, 0, 0, 0);
    chk_res("s2c", b + 2, -32768, 32768, -131072);
    chk("s2_done", n_done - nd, 1);

    // rejected writes: bad address while idle, good address while busy
    nw = n_werr;
    do_write(12, 77);
    set_s(0, 1, 1, 1, 0);
    b = got1.size();
    fork
      run_batch(1, -1, 0, 0);
      begin repeat (2) cyc_edge(); do_write(0, 99); end
    join
    chk("s3_werr", n_werr - nw, 2);
    chk("s3_d1", d1, 1);
    chk_res("s3", b, 6, 0, 15);

    // write accepted in the same cycle as start
    set_s(0, 1, 0, 0, 0);
    b = got1.size();
    run_batch(1, 0, 7, 0);
    chk_res("s7", b, 7, -1, 4);
    do_write(0, 1);

    // empty batch
    nb = n_busy; nx = n_xrdy; nd = n_done;
    run_batch(0, -1, 0, 0);
    chk("s4_busy", n_busy - nb, 1);
    chk("s4_xrdy", n_xrdy - nx, 0);
    chk("s4_done", n_done - nd, 1);

    // start pulsed mid-batch is ignored
    set_s(0, 1, 1, 1, 0);
    set_s(1, 2, -3, 1, 0);
    b = got1.size(); nd = n_done;
    fork
      run_batch(2, -1, 0, 0);
      begin repeat (3) cyc_edge(); start = 1'b1; batch_len = CNT_W'(5); cyc_edge(); start = 1'b0; end
    join
    chk("s6_count", got1.size() - b, 2);
    chk("s6_done", n_done - nd, 1);
    chk("s6_busy", busy, 0);

    // reset during WAIT of the second of four samples
    set_s(0, 1, 2, 3, 0);
    set_s(1, 4, 5, 6, 0);
    nd = n_done;
    start = 1'b1; batch_len = CNT_W'(4);
    cyc_edge();
    start = 1'b0;
    send_sample(0, 0);
    take_result(0);
    send_sample(1, 0);
    reset = 1'b1;
    cyc_edge();
    reset = 1'b0;
    chk("s5_busy", busy, 0);
    chk("s5_xr", x_ready, 0);
    chk("s5_yv", y_valid, 0);
    chk("s5_y1", y1, 0);
    chk("s5_p2", p2, 0);
    chk("s5_f3", f3, 0);
    chk("s5_cnt", sample_cnt, 0);
    repeat (3) cyc_edge();
    chk("s5_done", n_done - nd, 0);
    set_s(0, 5, 6, 7, 0);
    b = got1.size();
    run_batch(1, -1, 0, 0);
    chk_res("s5", b, 0, 0, 0);

    // randomized batches with concurrent writes
    repeat (40) begin
      repeat ($urandom_range(0, 3)) do_write($urandom_range(0, 15), $urandom_range(0, 65535) - 32768);
      len = $urandom_range(0, 5);
      for (int k = 0; k < len; k++)
        set_s(k, $urandom_range(0, 65535) - 32768, $urandom_range(0, 65535) - 32768,
              $urandom_range(0, 65535) - 32768, $urandom_range(0, 3));
      sa = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : -1;
      fork
        run_batch(len, sa, $urandom_range(0, 65535) - 32768, 1);
        begin
          repeat ($urandom_range(0, 3)) begin
            repeat ($urandom_range(2, 5)) cyc_edge();
            do_write($urandom_range(0, 15), $urandom_range(0, 65535) - 32768);
          end
        end
      join
    end

    repeat (3) cyc_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: simulation still running at %0t, expected completion earlier", $time);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

endmodule
